red_pitaya_pwm_demod: RTL and testbench
=======================================

// Module: red_pitaya_pwm_demod
// PURPOSE
//  Receive end of the slow-DAC PWM link: measures 4 looped-back PWM lines
//  and rebuilds the 24-bit code {8b integer, 16b dither} per channel.
//  Used for board self-test and calibration of the RC-filtered slow outputs.
//  Lives in the 2x DAC clock domain next to the PWM generator.
//  Frames are aligned by the generator's pwm sync pulse.
// PARAMETERS
//  PWM_FULL  156  cycles per PWM frame (100% value); count runs 1..PWM_FULL
//  SYNC_OFS  5    clk cycles from the pwm_sync_i sample to the first pwm_i sample of frame 0
// PORTS
//  dac_2clk_i   in   1   2x DAC clock; sole clock
//  dac_rst_i    in   1   synchronous reset, active-high
//  pwm_i        in   4   PWM lines, bit0=A..bit3=D, synchronous to dac_2clk_i
//  pwm_sync_i   in   1   1-cycle pulse, once per 16*PWM_FULL cycles
//  code_a_o     out  24  decoded code, channel A (B/C/D: code_b_o, code_c_o, code_d_o, same format)
//  code_vld_o   out  1   1-cycle pulse; all four codes updated together
//  locked_o     out  1   high while frame alignment is held
//  sync_err_o   out  1   1-cycle pulse on a misplaced or missing sync
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, all counters and arrays 0; applies mid-group too.
//  FSM IDLE: on pwm_sync_i -> ARM; load ofs counter = SYNC_OFS-1; load period cnt pcnt=0.
//  FSM ARM: count ofs down to 0 -> RUN with frame fcnt=0, cycle ccnt=0.
//  FSM RUN: each cycle, per channel, h[ch] += pwm_i[ch]; h is 8b and saturates at 255.
//   - ccnt==PWM_FULL-1: store h into hk[ch][fcnt]; clear h; ccnt=0; fcnt++ (wraps 15->0).
//   - fcnt==15 at frame end: copy hk to shadow and start the decode pipe.
//   - Capture continues into the next group with no gap.
//   - locked_o=1 from the first completed group.
//  Sync check: pcnt counts from 0 at each accepted sync; expected sync at pcnt==16*PWM_FULL-1.
//   - Sync at another pcnt, or no sync at the expected pcnt: sync_err_o=1 for 1 cycle.
//   - Same event: locked_o=0, group in progress discarded (no code_vld_o for it).
//   - Early sync re-arms immediately (-> ARM). Missing sync -> IDLE.
//  Decode pipe, per channel, on shadow values:
//   - stage 1: m = min(hk[0..15]).
//   - stage 2: code = {m, frac}, where frac[k] = (hk[k] != m).
//   - code_*_o registered; code_vld_o pulses with them.
//   - code_vld_o is 3 cycles after the pwm_i cycle holding the last sample of frame 15.
//   - code_*_o holds its value until the next code_vld_o; a discarded group leaves outputs unchanged.
//  Frame k carries dither bit k (bit0 in the first frame after sync).
//  Defined aliasing cases:
//   - frac 0xFFFF decodes as integer+1 with frac 0.
//   - h clamps at PWM_FULL, so integer >= PWM_FULL decodes as {PWM_FULL, frac of non-clamped frames}.
//   - Integer+dither wrapping past 255 in the generator is out of scope.
//  Simultaneous events:
//   - reset beats everything.
//   - A sync on the same cycle a group completes is judged by pcnt.
//   - A group completing on that cycle is decoded only if the sync is valid.
// TESTING
//  - ch A code 0x4D0000, sync every 2496 cycles:
//      -> after 2nd group, code_a_o=0x4D0000, locked_o=1, code_vld_o every 2496 cycles.
//  - ch B 0x20A5A5, ch C 0x000001, ch D 0x9B8000:
//      -> codes B/C/D match exactly in the same code_vld_o pulse.
//  - ch A 0x10FFFF -> 0x110000. ch A 0x9CFFFF -> 0x9C0000. ch A 0xC81234 -> 0x9C0000.
//  - Extra sync pulse at pcnt=700:
//      -> sync_err_o 1 cycle, locked_o=0, no code_vld_o for that group.
//      -> Relock; valid code after the next full group.
//  - Suppress one sync:
//      -> sync_err_o at pcnt=2495, FSM IDLE; recovers on the following sync.
//  - dac_rst_i high for 1 cycle mid-frame 7:
//      -> next cycle all outputs 0, FSM IDLE; no stale code_vld_o.

Source files
------------

// File: rtl/red_pitaya_pwm_demod.sv
// Receive end of the slow-DAC PWM loopback: counts high cycles per frame on four
// PWM lines and rebuilds each channel's {integer, 16-bit dither} code per 16-frame group.
module red_pitaya_pwm_demod #(
  parameter int unsigned PWM_FULL = 156,
  parameter int unsigned SYNC_OFS = 5
) (
  input  logic        dac_2clk_i,
  input  logic        dac_rst_i,
  input  logic [3:0]  pwm_i,
  input  logic        pwm_sync_i,
  output logic [23:0] code_a_o,
  output logic [23:0] code_b_o,
  output logic [23:0] code_c_o,
  output logic [23:0] code_d_o,
  output logic        code_vld_o,
  output logic        locked_o,
  output logic        sync_err_o
);

  localparam int unsigned GROUP = 16 * PWM_FULL;
  localparam int PW = $clog2(GROUP);
  localparam int CW = $clog2(PWM_FULL);
  localparam int OW = $clog2(SYNC_OFS + 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t         state_q, state_d;
  logic [OW-1:0]  ofs_q, ofs_d;
  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic [CW-1:0]  ccnt_q, ccnt_d;
  logic [3:0]     fcnt_q, fcnt_d;
  logic           sync_exp, sync_err, frame_end, group_ok;

  logic [3:0][7:0]        h_q, h_inc, m_q, m_d;
  logic [3:0][15:0][7:0]  hk_q, shadow_q;
  logic [3:0][15:0]       frac;
  logic [3:0][23:0]       code_q;
  logic [2:0]             go_q;
  logic                   vld_q, locked_q, err_q;

  always_comb begin
    state_d   = state_q;
    ofs_d     = ofs_q;
    pcnt_d    = pcnt_q + 1'b1;
    ccnt_d    = ccnt_q;
    fcnt_d    = fcnt_q;
    sync_err  = 1'b0;
    frame_end = 1'b0;
    group_ok  = 1'b0;
    sync_exp  = (pcnt_q == PW'(GROUP - 1));
    case (state_q)
      IDLE: begin
        pcnt_d = '0;
        if (pwm_sync_i) begin
          state_d = ARM;
          ofs_d   = OW'(SYNC_OFS - 1);
        end
      end
      ARM: begin
        ofs_d  = ofs_q - 1'b1;
        ccnt_d = '0;
        fcnt_d = '0;
        if (ofs_q <= OW'(1)) state_d = RUN;
      end
      RUN: begin
        frame_end = (ccnt_q == CW'(PWM_FULL - 1));
        if (frame_end) begin
          ccnt_d = '0;
          fcnt_d = fcnt_q + 1'b1;
        end else begin
          ccnt_d = ccnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outside IDLE every sync is judged against the period counter.
    if (state_q != IDLE) begin
      sync_err = pwm_sync_i ^ sync_exp;
      if (pwm_sync_i) pcnt_d = '0;
      if (sync_err && pwm_sync_i) begin
        state_d = ARM;
        ofs_d   = OW'(SYNC_OFS - 1);
      end else if (sync_err) begin
        state_d = IDLE;
      end
    end
    group_ok = frame_end && (fcnt_q == 4'd15) && !sync_err;
  end

  always_ff @(posedge dac_2clk_i) begin
    if (dac_rst_i) begin
      state_q <= IDLE;
      ofs_q   <= '0;
      pcnt_q  <= '0;
      ccnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ofs_q   <= ofs_d;
      pcnt_q  <= pcnt_d;
      ccnt_q  <= ccnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    for (int ch = 0; ch < 4; ch++) begin
      h_inc[ch] = (h_q[ch] == 8'hFF) ? h_q[ch] : h_q[ch] + {7'd0, pwm_i[ch]};
      m_d[ch] = shadow_q[ch][0];
      for (int k = 1; k < 16; k++) begin
        if (shadow_q[ch][k] < m_d[ch]) m_d[ch] = shadow_q[ch][k];
      end
      for (int k = 0; k < 16; k++) frac[ch][k] = (shadow_q[ch][k] != m_q[ch]);
    end
  end

  always_ff @(posedge dac_2clk_i) begin
    if (dac_rst_i) begin
      h_q      <= '0;
      hk_q     <= '0;
      shadow_q <= '0;
      m_q      <= '0;
      code_q   <= '0;
      go_q     <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        if (state_q != RUN) begin
          h_q[ch] <= '0;
        end else if (frame_end) begin
          hk_q[ch][fcnt_q] <= h_inc[ch];
          h_q[ch]          <= '0;
        end else begin
          h_q[ch] <= h_inc[ch];
        end
      end
      // shadow -> min -> code, one register each; the next group cannot disturb shadow in time
      go_q <= {go_q[1:0], group_ok};
      if (go_q[0]) shadow_q <= hk_q;
      if (go_q[1]) m_q <= m_d;
      vld_q <= go_q[2];
      if (go_q[2]) begin
        for (int ch = 0; ch < 4; ch++) code_q[ch] <= {m_q[ch], frac[ch]};
      end
      err_q <= sync_err;
      if (sync_err) locked_q <= 1'b0;
      else if (group_ok) locked_q <= 1'b1;
    end
  end

  assign code_a_o   = code_q[0];
  assign code_b_o   = code_q[1];
  assign code_c_o   = code_q[2];
  assign code_d_o   = code_q[3];
  assign code_vld_o = vld_q;
  assign locked_o   = locked_q;
  assign sync_err_o = err_q;

endmodule

// File: tb/tb_red_pitaya_pwm_demod.sv
// Drives a behavioural PWM generator with random and directed codes and checks the
// demodulator cycle by cycle against a group/sync event model.
module tb_red_pitaya_pwm_demod;

  localparam int FULL   = 156;
  localparam int GRP    = 16 * FULL;
  localparam int ORIGIN = 10;
  localparam int NCYC   = ORIGIN + GRP * 16 + 20;
  localparam int RST_AT = ORIGIN + GRP * 11 + 5 + 7 * FULL + 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pwm;
  logic        sync;
  logic [23:0] code_a, code_b, code_c, code_d;
  logic        vld, locked, serr;

  red_pitaya_pwm_demod dut (
    .dac_2clk_i (clk),
    .dac_rst_i  (rst),
    .pwm_i      (pwm),
    .pwm_sync_i (sync),
    .code_a_o   (code_a),
    .code_b_o   (code_b),
    .code_c_o   (code_c),
    .code_d_o   (code_d),
    .code_vld_o (vld),
    .locked_o   (locked),
    .sync_err_o (serr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [23:0] gen_code [0:16][0:3];

  // model state
  bit          m_active, m_locked, m_err, m_vld, m_prev_rst;
  int          m_next_exp, m_run_start, pend_t;
  logic [23:0] m_code [0:3];
  logic [23:0] pend_code [0:3];

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int frame_cnt(input logic [23:0] code, input int f);
    int n;
    n = int'(code[23:16]) + int'(code[f]);
    return (n > FULL) ? FULL : n;
  endfunction

  function automatic logic [23:0] decode(input logic [23:0] code);
    int mn;
    logic [15:0] fr;
    mn = 1000;
    for (int f = 0; f < 16; f++) if (frame_cnt(code, f) < mn) mn = frame_cnt(code, f);
    for (int f = 0; f < 16; f++) fr[f] = (frame_cnt(code, f) != mn);
    return {8'(mn), fr};
  endfunction

  function automatic bit sync_at(input int c);
    int rel;
    rel = c - ORIGIN;
    if (c == ORIGIN + GRP * 6 + 701) return 1'b1;
    if (c == ORIGIN + GRP * 14 + 4) return 1'b1;
    if (rel < 0 || rel % GRP != 0) return 1'b0;
    return (rel / GRP) != 9;
  endfunction

  function automatic logic [3:0] pwm_at(input int c);
    int gc, n, f, p;
    logic [3:0] v;
    v  = '0;
    gc = c - ORIGIN - 5;
    if (gc >= 0) begin
      n = gc / GRP;
      f = (gc % GRP) / FULL;
      p = gc % FULL;
      for (int ch = 0; ch < 4; ch++) v[ch] = (p < frame_cnt(gen_code[n][ch], f));
    end
    return v;
  endfunction

  task automatic model_step(input int c, input bit r, input bit s);
    bit done;
    int n;
    m_err = 1'b0;
    m_vld = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_locked = 1'b0;
      pend_t   = -1;
      for (int ch = 0; ch < 4; ch++) m_code[ch] = '0;
    end else begin
      if (pend_t == c) begin
        m_vld  = 1'b1;
        pend_t = -1;
        for (int ch = 0; ch < 4; ch++) m_code[ch] = pend_code[ch];
      end
      if (!m_active) begin
        if (s) begin
          m_active    = 1'b1;
          m_next_exp  = c + GRP;
          m_run_start = c + 5;
        end
      end else begin
        done  = (c >= m_run_start) && ((c - m_run_start) % GRP == GRP - 1);
        m_err = s ^ (c == m_next_exp);
        if (done && !m_err) begin
          m_locked = 1'b1;
          pend_t   = c + 3;
          n        = (c - ORIGIN - 2500) / GRP;
          for (int ch = 0; ch < 4; ch++) pend_code[ch] = decode(gen_code[n][ch]);
        end
        if (m_err) begin
          m_locked = 1'b0;
          if (s) begin
            m_next_exp  = c + GRP;
            m_run_start = c + 5;
          end else begin
            m_active = 1'b0;
          end
        end else if (s) begin
          m_next_exp = c + GRP;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("vld", 24'(vld), 24'(m_vld));
    chk("sync_err", 24'(serr), 24'(m_err));
    chk("locked", 24'(locked), 24'(m_locked));
    if (m_vld || m_prev_rst || (cyc % 64 == 0)) begin
      chk("code_a", code_a, m_code[0]);
      chk("code_b", code_b, m_code[1]);
      chk("code_c", code_c, m_code[2]);
      chk("code_d", code_d, m_code[3]);
    end
  endtask

  initial begin
    bit r, s;
    for (int n = 0; n <= 16; n++) begin
      for (int ch = 0; ch < 4; ch++) begin
        gen_code[n][ch] = {8'($urandom_range(160, 0)), 16'($urandom)};
      end
    end
    for (int n = 0; n <= 16; n++) if (n != 2 && n != 3 && n != 4) gen_code[n][0] = 24'h4D0000;
    gen_code[1][1] = 24'h20A5A5;
    gen_code[1][2] = 24'h000001;
    gen_code[1][3] = 24'h9B8000;
    gen_code[2][0] = 24'h10FFFF;
    gen_code[3][0] = 24'h9CFFFF;
    gen_code[4][0] = 24'hC81234;
    gen_code[5][1] = 24'h9BFFFF;
    gen_code[5][2] = 24'h00FFFE;

    m_active = 1'b0; m_locked = 1'b0; m_err = 1'b0; m_vld = 1'b0; m_prev_rst = 1'b0;
    m_next_exp = 0; m_run_start = 0; pend_t = -1;
    for (int ch = 0; ch < 4; ch++) begin
      m_code[ch] = '0;
      pend_code[ch] = '0;
    end
    rst = 1'b1; sync = 1'b0; pwm = '0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c > 0) check_outputs();
      cyc = c;
      r = (c < 5) || (c == RST_AT);
      s = sync_at(c);
      rst  = r;
      sync = s;
      pwm  = pwm_at(c);
      m_prev_rst = r;
      model_step(c, r, s);
    end
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
